// File: rtl/pe_array_feeder_pkg.sv
// Shared definitions for the PE array edge feeder: FSM state encodings and default array dimensions.
package pe_array_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ROWS       = 4;
  localparam int DEFAULT_COLS       = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WCOLLECT = 3'd1,
    ST_WPUSH    = 3'd2,
    ST_COMPUTE  = 3'd3,
    ST_FLUSH    = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/pe_array_feeder_skew_line.sv
// Registered enable+data delay line of DEPTH stages; data is only updated on enabled beats, so bubbles hold it.
module pe_skew_line
  import pe_array_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 1
) (
  input  logic                  PE_clk,
  input  logic                  PE_rst_n,
  input  logic                  in_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_en,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]      en_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      en_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      en_q[0] <= in_en;
      if (in_en) data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        en_q[i] <= en_q[i-1];
        if (en_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_en   = en_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/pe_array_feeder.sv
// Edge driver for a systolic PE array: buffers a weight tile, pushes it down the top edge,
// then streams activation vectors into the left edge with a one-cycle-per-row skew.
module pe_array_feeder
  import pe_array_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ROWS       = DEFAULT_ROWS,
  parameter int COLS       = DEFAULT_COLS
) (
  input  logic                       PE_clk,
  input  logic                       PE_rst_n,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic                       a_last,
  output logic                       arr_mode,
  output logic [COLS-1:0]            arr_en_up,
  output logic [COLS*DATA_WIDTH-1:0] arr_data_up,
  output logic [ROWS-1:0]            arr_en_left,
  output logic [ROWS*DATA_WIDTH-1:0] arr_data_left,
  output logic                       weights_loaded,
  output logic                       wload_done,
  output logic                       comp_done
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS - 1);
  localparam logic [CW-1:0] FLUSH_LAST = (ROWS > 1) ? CW'(ROWS - 2) : '0;

  feeder_state_t             state;
  logic [CW-1:0]             cnt;
  logic [COLS*DATA_WIDTH-1:0] wbuf [ROWS];
  logic                      w_fire;
  logic                      a_fire;
  logic [IW-1:0]             wr_idx;
  logic [IW-1:0]             push_idx;

  // A pending weight beat in IDLE wins, so a_ready is withheld while w_valid is high.
  always_comb begin
    w_ready  = (state == ST_IDLE) || (state == ST_WCOLLECT);
    a_ready  = (state == ST_COMPUTE) || ((state == ST_IDLE) && weights_loaded && !w_valid);
    w_fire   = w_valid && w_ready;
    a_fire   = a_valid && a_ready;
    wr_idx   = IW'(cnt);
    push_idx = IW'(LAST_ROW - cnt - 1'b1);
  end

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      arr_mode       <= 1'b0;
      arr_en_up      <= '0;
      arr_data_up    <= '0;
      weights_loaded <= 1'b0;
      wload_done     <= 1'b0;
      comp_done      <= 1'b0;
      for (int r = 0; r < ROWS; r++) wbuf[r] <= '0;
    end else begin
      wload_done <= 1'b0;
      comp_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_fire) begin
            wbuf[0] <= w_data;
            if (ROWS == 1) begin
              state          <= ST_WPUSH;
              cnt            <= '0;
              arr_mode       <= 1'b1;
              arr_en_up      <= '1;
              arr_data_up    <= w_data;
              weights_loaded <= 1'b0;
            end else begin
              state <= ST_WCOLLECT;
              cnt   <= CW'(1);
            end
          end else if (a_fire) begin
            if (a_last && ROWS > 1) begin
              state <= ST_FLUSH;
              cnt   <= '0;
            end else if (a_last) begin
              comp_done <= 1'b1;
            end else begin
              state <= ST_COMPUTE;
            end
          end
        end
        // The last row is pushed first, straight from the beat being accepted.
        ST_WCOLLECT: begin
          if (w_fire) begin
            wbuf[wr_idx] <= w_data;
            if (cnt == LAST_ROW) begin
              state          <= ST_WPUSH;
              cnt            <= '0;
              arr_mode       <= 1'b1;
              arr_en_up      <= '1;
              arr_data_up    <= w_data;
              weights_loaded <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_WPUSH: begin
          if (cnt == LAST_ROW) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            arr_mode       <= 1'b0;
            arr_en_up      <= '0;
            arr_data_up    <= '0;
            weights_loaded <= 1'b1;
            wload_done     <= 1'b1;
          end else begin
            arr_data_up <= wbuf[push_idx];
            cnt         <= cnt + 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (a_fire && a_last) begin
            if (ROWS > 1) begin
              state <= ST_FLUSH;
              cnt   <= '0;
            end else begin
              state     <= ST_IDLE;
              comp_done <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            comp_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    pe_skew_line #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (r + 1)
    ) u_line (
      .PE_clk  (PE_clk),
      .PE_rst_n(PE_rst_n),
      .in_en   (a_fire),
      .in_data (a_data[r*DATA_WIDTH +: DATA_WIDTH]),
      .out_en  (arr_en_left[r]),
      .out_data(arr_data_left[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Bench for pe_array_feeder: a behavioural 4x4 PE array captures pushed weights and left-edge vectors,
// and a time-indexed handshake history predicts the skewed left edge every cycle.
module tb_pe_array_feeder;

  localparam int DW   = 32;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int MAXV = 64;

  logic                 PE_clk;
  logic                 PE_rst_n;
  logic                 w_valid;
  logic                 w_ready;
  logic [COLS*DW-1:0]   w_data;
  logic                 a_valid;
  logic                 a_ready;
  logic [ROWS*DW-1:0]   a_data;
  logic                 a_last;
  logic                 arr_mode;
  logic [COLS-1:0]      arr_en_up;
  logic [COLS*DW-1:0]   arr_data_up;
  logic [ROWS-1:0]      arr_en_left;
  logic [ROWS*DW-1:0]   arr_data_left;
  logic                 weights_loaded;
  logic                 wload_done;
  logic                 comp_done;

  pe_array_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .PE_clk        (PE_clk),
    .PE_rst_n      (PE_rst_n),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_data        (a_data),
    .a_last        (a_last),
    .arr_mode      (arr_mode),
    .arr_en_up     (arr_en_up),
    .arr_data_up   (arr_data_up),
    .arr_en_left   (arr_en_left),
    .arr_data_left (arr_data_left),
    .weights_loaded(weights_loaded),
    .wload_done    (wload_done),
    .comp_done     (comp_done)
  );

  initial PE_clk = 1'b0;
  always #5 PE_clk = ~PE_clk;

  typedef struct {
    logic [ROWS*DW-1:0] a;
    bit                 last;
    logic [COLS*DW-1:0] sums;
  } vec_t;

  int                 n_vec = 0;
  int                 n_err = 0;
  bit                 hist_en [$];
  logic [ROWS*DW-1:0] hist_data [$];
  logic [DW-1:0]      exp_dl [ROWS];
  logic [DW-1:0]      pe_w [ROWS][COLS];
  logic [DW-1:0]      wmat [ROWS][COLS];
  logic [DW-1:0]      capt [ROWS][MAXV];
  int                 capt_n [ROWS];
  logic [ROWS*DW-1:0] vecs [$];
  int                 gaps [$];
  logic [DW-1:0]      exps [$];
  vec_t               tbl [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [COLS*DW-1:0] wd,
                               input logic av, input logic [ROWS*DW-1:0] ad, input logic al);
    w_valid = wv;
    w_data  = wd;
    a_valid = av;
    a_data  = ad;
    a_last  = al;
  endtask

  function automatic logic [ROWS*DW-1:0] rvec();
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = $urandom;
    return v;
  endfunction

  function automatic logic [COLS*DW-1:0] packRow(input int k);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = wmat[k][c];
    return v;
  endfunction

  task automatic clearModel();
    hist_en.delete();
    hist_data.delete();
    for (int r = 0; r < ROWS; r++) begin
      exp_dl[r] = '0;
      capt_n[r] = 0;
    end
  endtask

  // One clock: drive at the falling edge, check ready, feed the PE model, then check the skewed left edge.
  task automatic step(input logic wv, input logic [COLS*DW-1:0] wd, input logic av,
                      input logic [ROWS*DW-1:0] ad, input logic al,
                      input logic exp_wr, input logic exp_ar);
    logic               en;
    logic [ROWS*DW-1:0] tmp;
    int                 idx;
    applyStimulus(wv, wd, av, ad, al);
    #1;
    checkOutput("w_ready", w_ready, exp_wr);
    checkOutput("a_ready", a_ready, exp_ar);
    checkOutput("en_exclusive", (|arr_en_left) && (|arr_en_up), 1'b0);
    if (arr_mode && arr_en_up == '1) begin
      for (int r = ROWS - 1; r > 0; r--) pe_w[r] = pe_w[r-1];
      for (int c = 0; c < COLS; c++) pe_w[0][c] = arr_data_up[c*DW +: DW];
    end
    @(posedge PE_clk);
    hist_en.push_back(av && exp_ar);
    hist_data.push_back(ad);
    @(negedge PE_clk);
    for (int r = 0; r < ROWS; r++) begin
      idx = hist_en.size() - 1 - r;
      en  = (idx >= 0) ? hist_en[idx] : 1'b0;
      if (en) begin
        tmp       = hist_data[idx];
        exp_dl[r] = tmp[r*DW +: DW];
      end
      checkOutput($sformatf("en_left[%0d]", r), arr_en_left[r], en);
      checkOutput($sformatf("data_left[%0d]", r), arr_data_left[r*DW +: DW], exp_dl[r]);
      if (arr_en_left[r] && capt_n[r] < MAXV) begin
        capt[r][capt_n[r]] = arr_data_left[r*DW +: DW];
        capt_n[r]++;
      end
    end
  endtask

  // Loads wmat; abort_at >= 0 returns at the start of that push cycle.
  task automatic loadWeights(input int abort_at, input bit with_a);
    for (int k = 0; k < ROWS; k++) step(1'b1, packRow(k), with_a, rvec(), 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < ROWS; j++) begin
      if (j == abort_at) return;
      checkOutput("push_mode", arr_mode, 1'b1);
      checkOutput("push_en_up", arr_en_up, {COLS{1'b1}});
      checkOutput($sformatf("push_data_up[%0d]", j), arr_data_up, packRow(ROWS - 1 - j));
      checkOutput("push_loaded", weights_loaded, 1'b0);
      checkOutput("push_wload_done", wload_done, 1'b0);
      step(1'b0, '0, with_a, rvec(), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("post_mode", arr_mode, 1'b0);
    checkOutput("post_en_up", arr_en_up, '0);
    checkOutput("post_data_up", arr_data_up, '0);
    checkOutput("wload_done", wload_done, 1'b1);
    checkOutput("weights_loaded", weights_loaded, 1'b1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        checkOutput($sformatf("pe_weight[%0d][%0d]", r, c), pe_w[r][c], wmat[r][c]);
  endtask

  function automatic void modelSums();
    logic [ROWS*DW-1:0] v;
    logic [DW-1:0]      s;
    exps.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      for (int c = 0; c < COLS; c++) begin
        s = '0;
        for (int r = 0; r < ROWS; r++) s = s + wmat[r][c] * v[r*DW +: DW];
        exps.push_back(s);
      end
    end
  endfunction

  // Streams vecs (gaps[i] bubbles before vector i, a_last on the final one), then checks flush and column sums.
  task automatic runCompute();
    bit            in_pass;
    int            n;
    logic [DW-1:0] act;
    in_pass = 1'b0;
    n       = vecs.size();
    for (int r = 0; r < ROWS; r++) capt_n[r] = 0;
    for (int i = 0; i < n; i++) begin
      repeat (gaps[i]) step(1'b0, '0, 1'b0, rvec(), 1'b0, !in_pass, 1'b1);
      step(1'b0, '0, 1'b1, vecs[i], (i == n - 1), !in_pass, 1'b1);
      in_pass = 1'b1;
    end
    for (int f = 0; f < ROWS - 1; f++) begin
      checkOutput("comp_done_early", comp_done, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("comp_done", comp_done, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("comp_done_clear", comp_done, 1'b0);
    for (int r = 0; r < ROWS; r++) checkOutput($sformatf("row%0d_beats", r), capt_n[r], n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < COLS; c++) begin
        act = '0;
        for (int r = 0; r < ROWS; r++) act = act + pe_w[r][c] * ((i < capt_n[r]) ? capt[r][i] : '0);
        checkOutput($sformatf("col_sum[%0d][%0d]", i, c), act, exps[i*COLS + c]);
      end
  endtask

  task automatic tableCompute();
    vecs.delete(); gaps.delete(); exps.delete();
    for (int i = 0; i < 2; i++) begin
      vecs.push_back(tbl[i].a);
      gaps.push_back(0);
      for (int c = 0; c < COLS; c++) exps.push_back(tbl[i].sums[c*DW +: DW]);
    end
    runCompute();
  endtask

  task automatic randomCompute(input int n, input int max_gap);
    vecs.delete(); gaps.delete();
    for (int i = 0; i < n; i++) begin
      vecs.push_back(rvec());
      gaps.push_back($urandom_range(0, max_gap));
    end
    modelSums();
    runCompute();
  endtask

  task automatic setTableWeights();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wmat[r][c] = DW'(4 * r + c + 1);
  endtask

  initial begin
    tbl[0].a = {32'd1, 32'd1, 32'd1, 32'd1}; tbl[0].last = 1'b0;
    tbl[0].sums = {32'd40, 32'd36, 32'd32, 32'd28};
    tbl[1].a = {32'd0, 32'd0, 32'd0, 32'd1}; tbl[1].last = 1'b1;
    tbl[1].sums = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pe_w[r][c] = '0;

    PE_rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    clearModel();
    @(negedge PE_clk);
    @(negedge PE_clk);
    checkOutput("rst_mode", arr_mode, 1'b0);
    checkOutput("rst_en_up", arr_en_up, '0);
    checkOutput("rst_data_up", arr_data_up, '0);
    checkOutput("rst_en_left", arr_en_left, '0);
    checkOutput("rst_data_left", arr_data_left, '0);
    checkOutput("rst_loaded", weights_loaded, 1'b0);
    checkOutput("rst_wload_done", wload_done, 1'b0);
    checkOutput("rst_comp_done", comp_done, 1'b0);
    checkOutput("rst_w_ready", w_ready, 1'b1);
    checkOutput("rst_a_ready", a_ready, 1'b0);
    PE_rst_n = 1'b1;

    repeat (3) step(1'b0, '0, 1'b1, rvec(), 1'b0, 1'b1, 1'b0);

    setTableWeights();
    loadWeights(-1, 1'b0);
    tableCompute();

    // valid pattern 1,0,1 exposes the per-row skew of a bubble
    vecs.delete(); gaps.delete();
    vecs.push_back(rvec()); gaps.push_back(0);
    vecs.push_back(rvec()); gaps.push_back(1);
    modelSums();
    runCompute();

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wmat[r][c] = $urandom;
    loadWeights(-1, 1'b1);
    randomCompute(5, 2);
    randomCompute(1, 0);

    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) wmat[r][c] = $urandom_range(0, 1000);
      loadWeights(-1, p[0]);
      randomCompute($urandom_range(2, 6), 3);
    end

    setTableWeights();
    loadWeights(2, 1'b0);
    PE_rst_n = 1'b0;
    #1;
    checkOutput("abort_mode", arr_mode, 1'b0);
    checkOutput("abort_en_up", arr_en_up, '0);
    checkOutput("abort_data_up", arr_data_up, '0);
    checkOutput("abort_loaded", weights_loaded, 1'b0);
    checkOutput("abort_a_ready", a_ready, 1'b0);
    @(posedge PE_clk);
    #1;
    checkOutput("abort_wload_done", wload_done, 1'b0);
    checkOutput("abort_comp_done", comp_done, 1'b0);
    @(negedge PE_clk);
    PE_rst_n = 1'b1;
    clearModel();
    step(1'b0, '0, 1'b1, rvec(), 1'b0, 1'b1, 1'b0);
    checkOutput("abort_wload_after", wload_done, 1'b0);
    loadWeights(-1, 1'b0);
    tableCompute();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
